multiplier: RTL

- Iterative shift-add integer multiplier for the RV32M MUL/MULH/MULHSU/MULHU instructions.
- Sits beside the divider in the execute stage and uses the same request/ready pulse handshake, so the core's M-unit treats both blocks identically.
- One operand pair is accepted per request. One product bit-step is computed per cycle. A one-cycle ready pulse marks the result.

---
 rtl/mul_pkg.sv | 32 +++
 rtl/mul_operand_cond.sv | 51 +++++
 rtl/multiplier.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
//------------------------------------------------------------------------------
// Module   : mul_pkg
// Purpose  : Shared constants for the iterative shift-add multiplier:
//            datapath width, RV32M operation encodings, one-hot FSM states
//            and the iteration counter width.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mul_pkg;

    // Operand/result width; the op encodings and the 5-bit counter assume 32.
    localparam int XLEN = 32;

    // Iteration counter: one product bit per cycle, 32 iterations.
    localparam int CNT_W = 5;

    // Operation encodings carried on op_i.
    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

    // One-hot FSM state encoding.
    localparam int         STATE_W = 3;
    localparam logic [2:0] ST_IDLE = 3'b001;
    localparam logic [2:0] ST_BUSY = 3'b010;
    localparam logic [2:0] ST_FIN  = 3'b100;

endpackage : mul_pkg

`default_nettype wire

// File: rtl/mul_operand_cond.sv
//------------------------------------------------------------------------------
// Module   : mul_operand_cond
// Purpose  : Combinational operand conditioning for the multiplier. Decides
//            per operand whether it is read as signed (from the operation),
//            produces the unsigned magnitude of each operand and the sign of
//            the final product.
// Ports    : i_mul1  [XLEN] rs1 operand (multiplicand)
//            i_mul2  [XLEN] rs2 operand (multiplier)
//            i_op    [2]    operation encoding
//            o_abs1  [XLEN] |rs1| under the selected interpretation
//            o_abs2  [XLEN] |rs2| under the selected interpretation
//            o_neg   [1]    product must be negated at the end
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mul_operand_cond
    import mul_pkg::*;
#(
    parameter int XLEN_P = XLEN
) (
    input  logic [XLEN_P-1:0] i_mul1,
    input  logic [XLEN_P-1:0] i_mul2,
    input  logic [1:0]        i_op,
    output logic [XLEN_P-1:0] o_abs1,
    output logic [XLEN_P-1:0] o_abs2,
    output logic              o_neg
);

    logic w_signed1;
    logic w_signed2;
    logic w_sign1;
    logic w_sign2;

    // rs1 is signed for MULH and MULHSU, rs2 only for MULH.
    assign w_signed1 = (i_op == MUL_OP_MULH) || (i_op == MUL_OP_MULHSU);
    assign w_signed2 = (i_op == MUL_OP_MULH);

    assign w_sign1 = w_signed1 & i_mul1[XLEN_P-1];
    assign w_sign2 = w_signed2 & i_mul2[XLEN_P-1];

    // Two's-complement negate; the most negative value maps onto 2^(XLEN-1),
    // which is still representable as an unsigned magnitude.
    assign o_abs1 = w_sign1 ? (~i_mul1 + 1'b1) : i_mul1;
    assign o_abs2 = w_sign2 ? (~i_mul2 + 1'b1) : i_mul2;

    assign o_neg  = w_sign1 ^ w_sign2;

endmodule : mul_operand_cond

`default_nettype wire

// File: rtl/multiplier.sv
//------------------------------------------------------------------------------
// Module   : multiplier
// Purpose  : Iterative shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
//            One operand pair per request, one product bit per cycle, and a
//            one-cycle rdy_o pulse carrying the result. Accepts a new request
//            in the result cycle so back-to-back operations have no bubble.
// Ports    : clk    [1]    clock
//            rst    [1]    asynchronous active-high reset
//            mul1_i [XLEN] multiplicand (rs1)
//            mul2_i [XLEN] multiplier (rs2)
//            op_i   [2]    00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//            vld_i  [1]    request valid, held until accepted
//            res_o  [XLEN] result, valid while rdy_o is high
//            rdy_o  [1]    one-cycle result pulse
// Options  : MULTIPLIER_EARLY_TERM_EN - leave BUSY as soon as no multiplier
//            bits remain; results unchanged, latency 2 + msb_index(|rs2|).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multiplier
    import mul_pkg::*;
#(
    parameter int XLEN_P = XLEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN_P-1:0] mul1_i,
    input  logic [XLEN_P-1:0] mul2_i,
    input  logic [1:0]        op_i,
    input  logic              vld_i,
    output logic [XLEN_P-1:0] res_o,
    output logic              rdy_o
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(XLEN_P - 1);

    // Registered state and datapath.
    logic [STATE_W-1:0]  r_state;
    logic [1:0]          r_op;
    logic                r_neg;
    logic [2*XLEN_P-1:0] r_acc;
    logic [2*XLEN_P-1:0] r_mcand;
    logic [XLEN_P-1:0]   r_mplier;
    logic [CNT_W-1:0]    r_cnt;
    logic [XLEN_P-1:0]   r_res;
    logic                r_rdy;

    // Combinational helpers.
    logic [XLEN_P-1:0]   w_abs1;
    logic [XLEN_P-1:0]   w_abs2;
    logic                w_neg;
    logic                w_accept;
    logic                w_last;
    logic [2*XLEN_P-1:0] w_acc_next;
    logic [2*XLEN_P-1:0] w_prod;
    logic [XLEN_P-1:0]   w_res_sel;

    mul_operand_cond #(
        .XLEN_P (XLEN_P)
    ) u_operand_cond (
        .i_mul1 (mul1_i),
        .i_mul2 (mul2_i),
        .i_op   (op_i),
        .o_abs1 (w_abs1),
        .o_abs2 (w_abs2),
        .o_neg  (w_neg)
    );

    // A request is taken from IDLE or from the result cycle (FIN).
    assign w_accept = vld_i && ((r_state == ST_IDLE) || (r_state == ST_FIN));

    // Accumulator value after the current BUSY iteration.
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    // Final signed product and the half the instruction asks for. Computed from
    // w_acc_next so the result can be registered on the BUSY-to-FIN edge.
    assign w_prod    = r_neg ? (~w_acc_next + 1'b1) : w_acc_next;
    assign w_res_sel = (r_op == MUL_OP_MUL) ? w_prod[XLEN_P-1:0]
                                            : w_prod[2*XLEN_P-1:XLEN_P];

`ifdef MULTIPLIER_EARLY_TERM_EN
    // Once only bit 0 (or nothing) of the multiplier remains, this iteration
    // consumes the last contributing bit and the product is complete.
    assign w_last = (r_cnt == c_cnt_last) || (r_mplier[XLEN_P-1:1] == '0);
`else
    assign w_last = (r_cnt == c_cnt_last);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_op     <= MUL_OP_MUL;
            r_neg    <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_res    <= '0;
            r_rdy    <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            if (w_accept) begin
                r_op     <= op_i;
                r_neg    <= w_neg;
                r_mcand  <= {{XLEN_P{1'b0}}, w_abs1};
                r_mplier <= w_abs2;
                r_acc    <= '0;
                r_cnt    <= '0;
                r_state  <= ST_BUSY;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_IDLE;
                    end
                    ST_BUSY: begin
                        r_acc    <= w_acc_next;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        // Wraps to zero on the final fixed-length iteration.
                        r_cnt    <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_res   <= w_res_sel;
                            r_rdy   <= 1'b1;
                            r_state <= ST_FIN;
                        end
                    end
                    ST_FIN: begin
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign res_o = r_res;
    assign rdy_o = r_rdy;

endmodule : multiplier

`default_nettype wire
